instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter NUM_INSTRUCTIONS, default 13: number of 32-bit words loaded per session.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begins a load session when sampled high in IDLE or DONE.
REQ-005 byte_in  input  8  incoming instruction byte.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_we  output  1  instruction-memory write strobe.
REQ-009 mem_addr  output  32  byte address of the write, always word-aligned (4*index).
REQ-010 mem_wdata  output  32  instruction word being written.
REQ-011 busy  output  1  high in any state other than IDLE and DONE.
REQ-012 done  output  1  all NUM_INSTRUCTIONS words written (and the checksum phase finished, if compiled in).
REQ-013 error  output  1  checksum mismatch flag.

Function
REQ-014 FSM states: IDLE, RECV, WRITE, CHECK, DONE.
REQ-015 IDLE: start=1 -> RECV with word index 0 and byte count 0; otherwise stay in IDLE.
REQ-016 RECV: byte_ready=1; a byte is accepted on a rising edge where byte_valid and byte_ready are both 1.
REQ-017 Byte order is little-endian: the first accepted byte fills bits [7:0] and the fourth fills bits [31:24].
REQ-018 Acceptance of the 4th byte -> WRITE on the same edge; the byte count wraps to 0.
REQ-019 WRITE lasts exactly one cycle: mem_we=1, mem_addr=4*index, mem_wdata=assembled word, byte_ready=0.
REQ-020 Latency: mem_we is asserted in the cycle immediately after the edge that accepts the 4th byte; minimum 5 cycles per word.
REQ-021 After WRITE: index increments; if the new index equals NUM_INSTRUCTIONS -> CHECK (macro defined) or DONE (macro undefined); otherwise -> RECV.
REQ-022 mem_we=0 in every state except WRITE; mem_addr and mem_wdata hold their last values outside WRITE.
REQ-023 DONE: done=1 and byte_ready=0; start=1 -> RECV with index 0, done clears and error clears on that edge.
REQ-024 start sampled in RECV, WRITE or CHECK is ignored.
REQ-025 A byte_valid pulse while byte_ready=0 is not accepted and does not advance any counter.
REQ-026 The index counter never exceeds NUM_INSTRUCTIONS, and no write is ever issued at an address at or above 4*NUM_INSTRUCTIONS.

Reset
REQ-027 reset=1 at an edge forces IDLE from any state, including mid-word and during WRITE.
REQ-028 Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0.
REQ-029 Reset clears the index, the byte count, the partial word and the running checksum; a partially received word is discarded and never written.

Configuration
REQ-030 Macro INSTR_LOADER_CHECKSUM_EN defined: a running XOR of all written words is kept.
REQ-031 With the macro defined, CHECK accepts 4 more bytes (same handshake and byte order) forming the expected checksum, then goes to DONE.
REQ-032 With the macro defined, on entering DONE, error=1 if the received checksum differs from the running XOR, else error=0.
REQ-033 Macro undefined: CHECK is unreachable, no checksum logic exists, and error is tied to 0.

Structure
REQ-034 Shared package instr_loader_pkg holds the state enum, BYTES_PER_WORD=4 and WORD_WIDTH=32.
REQ-035 Byte assembly (shift register plus 2-bit byte count) lives in one sub-module, word_assembler, instantiated once and reused by CHECK.

Verification
REQ-036 NUM_INSTRUCTIONS=2; start, then bytes 13,00,50,00,93,00,A0,00 with continuous valid -> writes 0x00500013@0x0 and 0x00A00093@0x4, each mem_we exactly 1 cycle, then done=1.
REQ-037 byte_valid asserted only every 3rd cycle -> same words and addresses written; no byte dropped or duplicated.
REQ-038 reset after 2 bytes of word 1 -> no mem_we issued; all outputs at reset values; a subsequent full session writes from address 0.
REQ-039 start pulsed during RECV, and byte_valid held high during WRITE -> no restart; the word is not corrupted.
REQ-040 Macro defined, words 0x00500013 and 0x00A00093, checksum bytes 80,00,F0,00 -> done=1, error=0; checksum bytes 00,00,00,00 -> done=1, error=1.
REQ-041 DONE then start -> done and error clear; second session rewrites from address 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
package instr_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = 32;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );

endinterface

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte-to-word assembler; nextWord is the word completed by the
// byte currently offered, valid as a full word when wordDone is high.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept,
    input  logic [7:0]            byteIn,
    output logic [WORD_WIDTH-1:0] nextWord,
    output logic                  wordDone
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    // Earlier bytes shift down so the first accepted byte ends up in [7:0].
    logic [WORD_WIDTH-9:0] shiftReg;
    logic [CNT_W-1:0]      byteCnt;

    assign nextWord = {byteIn, shiftReg};
    assign wordDone = accept && (byteCnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            shiftReg <= '0;
            byteCnt  <= '0;
        end else if (accept) begin
            shiftReg <= nextWord[WORD_WIDTH-1:8];
            byteCnt  <= byteCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams bytes into NUM_INSTRUCTIONS instruction words and writes them out.
// Optional trailing checksum word compiled in with INSTR_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// RECV  | accepting data bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CHECK | accepting the four checksum bytes
// DONE  | session complete, waiting for start
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int NUM_INSTRUCTIONS = 13
) (
    input  logic           clk,
    input  logic           reset,
    instr_loader_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_INSTRUCTIONS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INSTRUCTIONS);

    state_t                state;
    logic [IDX_W-1:0]      wordIdx;
    logic [IDX_W-1:0]      idxNext;
    logic                  accept;
    logic [WORD_WIDTH-1:0] nextWord;
    logic                  wordDone;

    assign accept  = bus.byte_valid & bus.byte_ready;
    assign idxNext = wordIdx + IDX_W'(1);

    word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .byteIn   (bus.byte_in),
        .nextWord (nextWord),
        .wordDone (wordDone)
    );

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] xorAcc;

    always_ff @(posedge clk) begin
        if (reset) begin
            xorAcc <= '0;
        end else if ((state == IDLE || state == DONE) && bus.start) begin
            xorAcc <= '0;
        end else if (state == RECV && wordDone) begin
            xorAcc <= xorAcc ^ nextWord;
        end
    end
`else
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wordIdx        <= '0;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            bus.error      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state          <= RECV;
                        wordIdx        <= '0;
                        bus.byte_ready <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        bus.error      <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (wordDone) begin
                        state          <= WRITE;
                        bus.byte_ready <= 1'b0;
                        bus.mem_we     <= 1'b1;
                        bus.mem_addr   <= WORD_WIDTH'(wordIdx) << 2;
                        bus.mem_wdata  <= nextWord;
                    end
                end
                WRITE: begin
                    bus.mem_we <= 1'b0;
                    wordIdx    <= idxNext;
                    if (idxNext == LAST_IDX) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state          <= CHECK;
                        bus.byte_ready <= 1'b1;
`else
                        state          <= DONE;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
`endif
                    end else begin
                        state          <= RECV;
                        bus.byte_ready <= 1'b1;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (wordDone) begin
                        state          <= DONE;
                        bus.byte_ready <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.error      <= (nextWord != xorAcc);
                    end
                end
`endif
                default: begin
                    state          <= IDLE;
                    bus.byte_ready <= 1'b0;
                    bus.mem_we     <= 1'b0;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader with NUM_INSTRUCTIONS=2: table vectors,
// directed reset/start corner cases and randomized sessions against a byte model.
module tb_instr_loader;

    localparam int N = 2;

    logic clk;
    logic reset;

    instr_loader_if bus();

    instr_loader #(.NUM_INSTRUCTIONS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [8*4*N-1:0] data;
        logic [31:0]      csum;
        int               gap;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic             errIfChecked;
    } vec_t;

    wr_t  wrLog[$];
    int   checks = 0;
    int   errors = 0;
    int   weDouble = 0;
    int   badAddr = 0;
    logic prevWe = 1'b0;

    // Write monitor: records every strobe, flags multi-cycle strobes and out-of-range addresses.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wrLog.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
            if (bus.mem_addr >= 32'(4 * N)) badAddr <= badAddr + 1;
            if (prevWe) weDouble <= weDouble + 1;
        end
        prevWe <= (bus.mem_we === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pickGap(input int gapMode);
        if (gapMode < 0) return $urandom_range(0, 3);
        return gapMode;
    endfunction

    // Reference model: words built from bytes by place value, addresses are 4*i.
    function automatic logic [32*N-1:0] modelWords(input logic [8*4*N-1:0] bytesIn);
        logic [32*N-1:0] w;
        longint acc;
        w = '0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < 4; j++)
                acc += longint'(bytesIn[8*(4*i+j) +: 8]) * (longint'(1) << (8*j));
            w[32*i +: 32] = acc[31:0];
        end
        return w;
    endfunction

    function automatic logic expectedError(input logic [32*N-1:0] words, input logic [31:0] csum);
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < N; i++) x = x ^ words[32*i +: 32];
        return (x != csum);
`else
        return 1'b0;
`endif
    endfunction

    task automatic sendByte(input logic [7:0] b, input int gap);
        int budget;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) tick();
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        budget = 50;
        while (bus.byte_ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got %b expected 1", bus.byte_ready);
        end else begin
            tick();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 0);
        check({tag, "_mem_we"},     32'(bus.mem_we), 0);
        check({tag, "_mem_addr"},   bus.mem_addr, 0);
        check({tag, "_mem_wdata"},  bus.mem_wdata, 0);
        check({tag, "_busy"},       32'(bus.busy), 0);
        check({tag, "_done"},       32'(bus.done), 0);
        check({tag, "_error"},      32'(bus.error), 0);
    endtask

    task automatic runSession(input logic [8*4*N-1:0] dataBytes, input logic [31:0] csum,
                              input int gapMode, input int startAt);
        wrLog.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_done_clr", 32'(bus.done), 0);
        check("start_err_clr", 32'(bus.error), 0);
        check("start_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 4*N; k++) begin
            if (k == startAt) begin
                bus.byte_valid = 1'b0;
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
            sendByte(dataBytes[8*k +: 8], pickGap(gapMode));
            if (k % 4 == 3) begin
                check("we_latency", 32'(bus.mem_we), 1);
                check("we_addr", bus.mem_addr, 32'(4 * (k / 4)));
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) sendByte(csum[8*k +: 8], pickGap(gapMode));
`endif
        bus.byte_valid = 1'b0;
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    endtask

    task automatic checkSession(input logic [32*N-1:0] expWords, input logic expErr);
        check("write_count", wrLog.size(), N);
        for (int i = 0; i < N && i < wrLog.size(); i++) begin
            check("write_addr", wrLog[i].a, 32'(4 * i));
            check("write_data", wrLog[i].d, expWords[32*i +: 32]);
        end
        check("done", 32'(bus.done), 1);
        check("busy_done", 32'(bus.busy), 0);
        check("ready_done", 32'(bus.byte_ready), 0);
        check("error", 32'(bus.error), 32'(expErr));
        check("we_single_cycle", weDouble, 0);
        check("addr_in_range", badAddr, 0);
    endtask

    vec_t vecs[4];

    initial begin
        logic [8*4*N-1:0] rndData;
        logic [32*N-1:0]  rndWords;
        logic [31:0]      rndCsum;
        logic             eErr;

        vecs[0] = '{data: 64'h00A00093_00500013, csum: 32'h00F00080, gap: 0,
                    w0: 32'h00500013, w1: 32'h00A00093, errIfChecked: 1'b0};
        vecs[1] = '{data: 64'h00A00093_00500013, csum: 32'h00F00080, gap: 2,
                    w0: 32'h00500013, w1: 32'h00A00093, errIfChecked: 1'b0};
        vecs[2] = '{data: 64'h00A00093_00500013, csum: 32'h00000000, gap: 1,
                    w0: 32'h00500013, w1: 32'h00A00093, errIfChecked: 1'b1};
        vecs[3] = '{data: 64'h01234567_DEADBEEF, csum: 32'hDF8EFB88, gap: 0,
                    w0: 32'hDEADBEEF, w1: 32'h01234567, errIfChecked: 1'b0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        tick();
        tick();
        checkResetOutputs("reset");
        reset = 1'b0;
        tick();

        // Stray valid pulses in IDLE must not be consumed.
        bus.byte_in = 8'hFF;
        bus.byte_valid = 1'b1;
        repeat (3) tick();
        bus.byte_valid = 1'b0;

        foreach (vecs[i]) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            eErr = vecs[i].errIfChecked;
`else
            eErr = 1'b0;
`endif
            runSession(vecs[i].data, vecs[i].csum, vecs[i].gap, -1);
            checkSession({vecs[i].w1, vecs[i].w0}, eErr);
        end

        // Stray valid pulses in DONE, then a new session must still start from a clean word.
        bus.byte_in = 8'h5A;
        bus.byte_valid = 1'b1;
        repeat (3) tick();
        bus.byte_valid = 1'b0;
        check("done_holds", 32'(bus.done), 1);
        runSession(vecs[0].data, vecs[0].csum, 0, -1);
        checkSession({vecs[0].w1, vecs[0].w0}, 1'b0);

        // Start pulsed mid-word in RECV is ignored.
        runSession(vecs[3].data, vecs[3].csum, 0, 2);
        checkSession({vecs[3].w1, vecs[3].w0}, 1'b0);

        // Reset after two bytes of the second word: no further write, clean outputs.
        wrLog.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) sendByte(vecs[0].data[8*k +: 8], 0);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        checkResetOutputs("midword");
        check("midword_writes", wrLog.size(), 1);
        reset = 1'b0;
        repeat (3) tick();
        check("midword_writes_after", wrLog.size(), 1);
        check("midword_idle_busy", 32'(bus.busy), 0);
        runSession(vecs[3].data, vecs[3].csum, 1, -1);
        checkSession({vecs[3].w1, vecs[3].w0}, 1'b0);

        // Reset landing on the WRITE cycle.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) sendByte(vecs[0].data[8*k +: 8], 0);
        check("write_cycle_we", 32'(bus.mem_we), 1);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        checkResetOutputs("in_write");
        reset = 1'b0;
        tick();
        runSession(vecs[0].data, vecs[0].csum, 0, -1);
        checkSession({vecs[0].w1, vecs[0].w0}, 1'b0);

        // Randomized sessions against the byte-level model.
        for (int s = 0; s < 20; s++) begin
            rndData  = {$urandom, $urandom};
            rndWords = modelWords(rndData);
            rndCsum  = rndWords[31:0] ^ rndWords[63:32];
            if ($urandom_range(0, 2) == 0) rndCsum = $urandom;
            runSession(rndData, rndCsum, -1, -1);
            checkSession(rndWords, expectedError(rndWords, rndCsum));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
